// File: rtl/mem_model_arb.sv
// Multi-port behavioural bench memory: round-robin arbitrated OBI-style channels sharing one word array.
// Optional pseudo-random grant stalls are enabled with `define MEM_MODEL_STALL_EN.
module mem_model_arb #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned MEM_W     = 32,
    parameter int unsigned MEM_SZ    = 262144,
    parameter int unsigned LATENCY   = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_PORTS-1:0]         req_i,
    input  logic [NUM_PORTS*32-1:0]      addr_i,
    input  logic [NUM_PORTS-1:0]         we_i,
    input  logic [NUM_PORTS*MEM_W/8-1:0] be_i,
    input  logic [NUM_PORTS*MEM_W-1:0]   wdata_i,
    output logic [NUM_PORTS-1:0]         gnt_o,
    output logic [NUM_PORTS-1:0]         rvalid_o,
    output logic [NUM_PORTS-1:0]         err_o,
    output logic [NUM_PORTS*MEM_W-1:0]   rdata_o,
    output logic                         prog_end_o
);

    localparam int unsigned BYTES  = MEM_W / 8;
    localparam int unsigned WORDS  = MEM_SZ / BYTES;
    localparam int unsigned IDX_LO = $clog2(BYTES);
    localparam int unsigned IDX_HI = $clog2(MEM_SZ);
    localparam int unsigned PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef struct packed {
        logic             valid;
        logic [PTR_W-1:0] port;
        logic             err;
        logic [MEM_W-1:0] rdata;
    } rsp_t;

    logic [MEM_W-1:0] mem [WORDS];

    logic [PTR_W-1:0]       rr;
    logic [PTR_W-1:0]       sel;
    logic [PTR_W-1:0]       cand;
    logic                   any_req;
    logic                   stall;
    logic                   gnt_any;
    logic [31:0]            g_addr;
    logic                   g_we;
    logic [BYTES-1:0]       g_be;
    logic [MEM_W-1:0]       g_wdata;
    logic [IDX_HI-IDX_LO-1:0] g_idx;
    logic                   g_err;
    logic                   unused_addr_bits;
    rsp_t                   rsp_in;
    rsp_t                   rsp_out;
    rsp_t                   pipe [LATENCY];

`ifdef MEM_MODEL_STALL_EN
    // Fibonacci LFSR, taps 16,14,13,11; bit 0 high blocks grants for that cycle
    logic [15:0] lfsr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    // Round-robin search starting at rr
    always_comb begin
        sel     = '0;
        cand    = '0;
        any_req = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand = PTR_W'((32'(rr) + i) % NUM_PORTS);
            if (!any_req && req_i[cand]) begin
                any_req = 1'b1;
                sel     = cand;
            end
        end
    end

    assign gnt_any    = any_req && !stall && !rst_i;
    assign gnt_o      = gnt_any ? (NUM_PORTS'(1) << sel) : '0;
    assign prog_end_o = gnt_o[0] && (addr_i[31:0] == 32'h0);

    assign g_addr  = addr_i[32'(sel)*32 +: 32];
    assign g_we    = we_i[sel];
    assign g_be    = be_i[32'(sel)*BYTES +: BYTES];
    assign g_wdata = wdata_i[32'(sel)*MEM_W +: MEM_W];
    assign g_idx   = g_addr[IDX_HI-1:IDX_LO];
    assign g_err   = |g_addr[31:IDX_HI];

    assign unused_addr_bits = ^g_addr[IDX_LO-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr <= '0;
        end else if (gnt_any) begin
            rr <= PTR_W'((32'(sel) + 1) % NUM_PORTS);
        end
    end

    // Byte-enabled write; out-of-range writes are dropped
    always_ff @(posedge clk_i) begin
        if (gnt_any && g_we && !g_err) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (g_be[b]) begin
                    mem[g_idx][b*8 +: 8] <= g_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        rsp_in       = '0;
        rsp_in.valid = gnt_any;
        rsp_in.port  = sel;
        rsp_in.err   = g_err;
        if (gnt_any && !g_we && !g_err) begin
            rsp_in.rdata = mem[g_idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= rsp_in;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign rsp_out = pipe[LATENCY-1];

    // Route the pipeline head to its port; everything reads as zero during reset
    always_comb begin
        rvalid_o = '0;
        err_o    = '0;
        rdata_o  = '0;
        if (!rst_i && rsp_out.valid) begin
            rvalid_o[rsp_out.port]                   = 1'b1;
            err_o[rsp_out.port]                      = rsp_out.err;
            rdata_o[32'(rsp_out.port)*MEM_W +: MEM_W] = rsp_out.rdata;
        end
    end

endmodule

// File: tb/tb_mem_model_arb.sv
// Directed bench for mem_model_arb: three instances (LATENCY 1, 2, 3) share one stimulus bus.
module tb_mem_model_arb;

    logic        clk = 1'b0;
    logic        rst1, rst2, rst3;
    logic [1:0]  req;
    logic [63:0] addr;
    logic [1:0]  we;
    logic [7:0]  be;
    logic [63:0] wdata;

    logic [1:0]  gnt1, rv1, err1, gnt2, rv2, err2, gnt3, rv3, err3;
    logic [63:0] rdata1, rdata2, rdata3;
    logic        pe1, pe2, pe3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_model_arb #(.NUM_PORTS(2), .MEM_W(32), .MEM_SZ(262144), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst1), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
        .wdata_i(wdata), .gnt_o(gnt1), .rvalid_o(rv1), .err_o(err1), .rdata_o(rdata1),
        .prog_end_o(pe1));

    mem_model_arb #(.NUM_PORTS(2), .MEM_W(32), .MEM_SZ(262144), .LATENCY(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst2), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
        .wdata_i(wdata), .gnt_o(gnt2), .rvalid_o(rv2), .err_o(err2), .rdata_o(rdata2),
        .prog_end_o(pe2));

    mem_model_arb #(.NUM_PORTS(2), .MEM_W(32), .MEM_SZ(262144), .LATENCY(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst3), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
        .wdata_i(wdata), .gnt_o(gnt3), .rvalid_o(rv3), .err_o(err3), .rdata_o(rdata3),
        .prog_end_o(pe3));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        req = '0; we = '0; be = '0; addr = '0; wdata = '0;
    endtask

    task automatic set_req(input int p, input logic w, input logic [31:0] a,
                           input logic [3:0] b, input logic [31:0] d);
        req[p]         = 1'b1;
        we[p]          = w;
        addr[p*32 +: 32] = a;
        be[p*4 +: 4]   = b;
        wdata[p*32 +: 32] = d;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
        idle();
        nxt();
        nxt();
        rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] ref_lfsr;
        logic [1:0]  eg;
        logic [1:0]  erv;
        int          p;

        rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
        idle();
        // Requests during reset, including a port-0 access to address 0
        set_req(0, 1'b0, 32'h0, 4'h0, 32'h0);
        set_req(1, 1'b1, 32'h100, 4'hF, 32'h1111_1111);
        nxt();
        @(negedge clk);
        check("rst_gnt", 64'(gnt1), 64'h0);
        check("rst_rvalid", 64'(rv1), 64'h0);
        check("rst_prog_end", 64'(pe1), 64'h0);
        check("rst_rdata", rdata1, 64'h0);
        nxt();
        idle();
        rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;

`ifdef MEM_MODEL_STALL_EN
        // Grants only where the reference LFSR bit 0 is clear
        ref_lfsr = 16'hACE1;
        for (int k = 0; k < 40; k++) begin
            idle();
            set_req(0, 1'b0, 32'h100, 4'h0, 32'h0);
            @(negedge clk);
            check($sformatf("stall_gnt_%0d", k), 64'(gnt1), 64'({1'b0, ~ref_lfsr[0]}));
            ref_lfsr = {ref_lfsr[0] ^ ref_lfsr[2] ^ ref_lfsr[3] ^ ref_lfsr[5], ref_lfsr[15:1]};
            nxt();
        end
        idle();
`else
        // Partial write then readback on port 1, LATENCY 1
        set_req(1, 1'b1, 32'h100, 4'hF, 32'h0);
        @(negedge clk);
        check("A_gnt_w0", 64'(gnt1), 64'h2);
        nxt();
        idle();
        set_req(1, 1'b1, 32'h100, 4'b0101, 32'hDEAD_BEEF);
        @(negedge clk);
        check("A_gnt_w1", 64'(gnt1), 64'h2);
        check("A_rv_w0", 64'(rv1), 64'h2);
        check("A_err_w0", 64'(err1), 64'h0);
        nxt();
        idle();
        set_req(1, 1'b0, 32'h100, 4'h0, 32'h0);
        @(negedge clk);
        check("A_gnt_rd", 64'(gnt1), 64'h2);
        check("A_rv_w1", 64'(rv1), 64'h2);
        nxt();
        idle();
        @(negedge clk);
        check("A_rv_rd", 64'(rv1), 64'h2);
        check("A_err_rd", 64'(err1), 64'h0);
        check("A_rdata", 64'(rdata1[63:32]), 64'h00AD_00EF);
        nxt();

        // Both ports requesting continuously after reset alternate 0,1,0,1
        reset_all();
        for (int k = 0; k < 5; k++) begin
            idle();
            if (k < 4) begin
                set_req(0, 1'b0, 32'h100, 4'h0, 32'h0);
                set_req(1, 1'b0, 32'h100, 4'h0, 32'h0);
            end
            eg  = (k < 4) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            erv = (k == 0) ? 2'b00 : (((k - 1) % 2 == 0) ? 2'b01 : 2'b10);
            @(negedge clk);
            check($sformatf("B_gnt_%0d", k), 64'(gnt1), 64'(eg));
            check($sformatf("B_rv_%0d", k), 64'(rv1), 64'(erv));
            if (k > 0) begin
                p = (k - 1) % 2;
                check($sformatf("B_rdata_%0d", k), 64'(rdata1[p*32 +: 32]), 64'h00AD_00EF);
            end
            nxt();
        end

        // LATENCY 3 read of a preloaded word: response only three cycles after grant
        idle();
        set_req(0, 1'b1, 32'h4, 4'hF, 32'h1234_5678);
        nxt();
        idle();
        nxt();
        nxt();
        nxt();
        for (int k = 0; k < 5; k++) begin
            idle();
            if (k == 0) set_req(0, 1'b0, 32'h4, 4'h0, 32'h0);
            @(negedge clk);
            check($sformatf("C_rv3_%0d", k), 64'(rv3), (k == 3) ? 64'h1 : 64'h0);
            if (k == 3) check("C_rdata3", 64'(rdata3[31:0]), 64'h1234_5678);
            nxt();
        end

        // Out-of-range accesses: error response, no write, zero read data
        idle();
        set_req(1, 1'b1, 32'h0, 4'hF, 32'hCAFE_F00D);
        nxt();
        idle();
        set_req(1, 1'b1, 32'h0004_0000, 4'hF, 32'hFFFF_FFFF);
        @(negedge clk);
        check("D_gnt_err_w", 64'(gnt1), 64'h2);
        nxt();
        idle();
        set_req(1, 1'b0, 32'h0004_0000, 4'h0, 32'h0);
        @(negedge clk);
        check("D_rv_err_w", 64'(rv1), 64'h2);
        check("D_err_w", 64'(err1), 64'h2);
        nxt();
        idle();
        set_req(1, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        check("D_err_r", 64'(err1), 64'h2);
        check("D_rdata_err_r", 64'(rdata1[63:32]), 64'h0);
        nxt();
        idle();
        @(negedge clk);
        check("D_err_word0", 64'(err1), 64'h0);
        check("D_word0", 64'(rdata1[63:32]), 64'hCAFE_F00D);
        nxt();

        // prog_end pulses only in the grant cycle of a port-0 access to address 0
        idle();
        @(negedge clk);
        check("E_pe_idle", 64'(pe1), 64'h0);
        nxt();
        set_req(0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        check("E_pe_gnt", 64'(pe1), 64'h1);
        check("E_gnt", 64'(gnt1), 64'h1);
        nxt();
        idle();
        @(negedge clk);
        check("E_pe_after", 64'(pe1), 64'h0);
        check("E_rv", 64'(rv1), 64'h1);
        nxt();

        // Reset at t+LATENCY-1 drops the in-flight LATENCY 2 response
        set_req(0, 1'b0, 32'h100, 4'h0, 32'h0);
        nxt();
        idle();
        rst2 = 1'b1;
        @(negedge clk);
        check("F_rv1_ref", 64'(rv1), 64'h1);
        check("F_rv2_in_rst", 64'(rv2), 64'h0);
        nxt();
        rst2 = 1'b0;
        @(negedge clk);
        check("F_rv2_drop", 64'(rv2), 64'h0);
        nxt();
        @(negedge clk);
        check("F_rv2_late", 64'(rv2), 64'h0);
        nxt();

        // Without stalls a pending request is granted every cycle
        for (int k = 0; k < 6; k++) begin
            idle();
            set_req(0, 1'b0, 32'h100, 4'h0, 32'h0);
            @(negedge clk);
            check($sformatf("G_gnt_%0d", k), 64'(gnt1), 64'h1);
            nxt();
        end
        idle();
`endif

        nxt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_model_arb.md
# mem_model_arb

Parametrised multi-port behavioural memory for the cv32e40x SoC benches. It generalises the single-port, fixed-latency bench memory to NUM_PORTS OBI-style request channels sharing one word array. Channels are served through a round-robin arbiter with a grant handshake, a configurable response latency and optional pseudo-random stalls. The block sits between the core wrapper's instruction/data (and later vector) memory ports and the bench's program loader and dump logic, which access `mem` hierarchically.

## Interface
- NUM_PORTS, 2, number of request channels (1..8); port 0 has initial priority
- MEM_W, 32, word width in bits; multiple of 32
- MEM_SZ, 262144, memory size in bytes; power of two
- LATENCY, 1, cycles from grant to response (>=1)
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- req_i  in  NUM_PORTS  request per channel; held until granted
- addr_i  in  NUM_PORTS*32  byte address per channel
- we_i  in  NUM_PORTS  write enable per channel
- be_i  in  NUM_PORTS*MEM_W/8  byte enables per channel
- wdata_i  in  NUM_PORTS*MEM_W  write data per channel
- gnt_o  out  NUM_PORTS  combinational grant, one-hot or zero
- rvalid_o  out  NUM_PORTS  response valid pulse per channel
- err_o  out  NUM_PORTS  response error, qualified by rvalid_o
- rdata_o  out  NUM_PORTS*MEM_W  read data, qualified by rvalid_o
- prog_end_o  out  1  pulse: a request from port 0 to address 0 is granted

## Operation
- Storage: `mem[MEM_SZ/(MEM_W/8)]` of MEM_W bits. Not cleared by reset; the bench loads it.
- Word index: addr[$clog2(MEM_SZ)-1 : $clog2(MEM_W/8)]. Low byte-offset bits are ignored.
- Error: addr[31:$clog2(MEM_SZ)] != 0.
  - Erroring writes do not modify `mem`.
  - Erroring reads return rdata 0.
- Arbiter: single array port, so at most one grant per cycle.
  - Round-robin pointer `rr`. Search order is rr, rr+1, …, wrapping modulo NUM_PORTS.
  - After a grant to port p, rr = (p+1) mod NUM_PORTS. Without a grant, rr is unchanged.
- Granted access:
  - Write: updates the enabled bytes at the grant-cycle edge.
  - Read: samples mem[idx] in the grant cycle, before any same-edge update. Only one access occurs per cycle, so no same-cycle conflict exists.
- Every grant, read or write, produces exactly one response to the granting port.
- Response pipeline: LATENCY stages carrying {valid, port id, err, rdata}.
- rvalid_o[p] is high for exactly one cycle. At most one bit of rvalid_o is set per cycle.
- prog_end_o asserts combinationally with gnt_o[0] when addr_i port 0 == 0.

## Timing
- Request in cycle t with no competitor and no stall: gnt_o high in cycle t. Response in cycle t+LATENCY.
- Write in cycle t followed by a read of the same word in t+1 returns the new data.
- Channels that are not granted keep req_i and their payload stable; the model does not check this.
- Throughput: one access per cycle aggregate.
- Back-to-back grants to one port yield back-to-back responses in order.
- Reset asserted in any cycle: the next cycle has rr=0, pipeline valids cleared, LFSR reseeded.
  - While rst_i=1: gnt_o, rvalid_o, err_o, prog_end_o = 0 and rdata_o = 0.
  - In-flight responses are dropped, not delivered after reset.
- Requests during reset are ignored: no grant and no write.

## Configuration
- `MEM_MODEL_STALL_EN` defined: 16-bit Fibonacci LFSR with taps 16,14,13,11, reset seed 16'hACE1, advances every cycle out of reset.
  - While LFSR bit 0 = 1, no grant is issued, even if requests are pending.
  - rr is held during a stall.
  - Responses already in flight are unaffected.
- Not defined: no LFSR is present, and a grant is issued in every cycle with any req_i set.

## Test plan
- LATENCY=1, port 1 writes 32'hDEADBEEF with be=4'b0101 to 0x100 (old word 0), then port 1 reads 0x100 -> rvalid at t+1, rdata 32'h00AD00EF, err 0.
- Ports 0 and 1 request continuously for 4 cycles after reset -> grants 0,1,0,1; responses follow at the same spacing, each on its own port.
- LATENCY=3, port 0 read of 0x4 (preloaded 32'h12345678) at cycle 10 -> rvalid_o[0] only in cycle 13, data 32'h12345678.
- Port 1 write to 0x0004_0000 (MEM_SZ=262144) -> gnt, then err 1 at t+LATENCY; a later read of word 0 is unchanged.
- Port 0 read of address 0 -> prog_end_o pulses in the grant cycle. rst_i asserted at t+LATENCY-1 with LATENCY=2 -> no rvalid is ever delivered.
- `MEM_MODEL_STALL_EN` defined, port 0 requests continuously from reset release -> grants occur exactly in the cycles where LFSR bit 0 = 0. The stall pattern matches a reference LFSR seeded 16'hACE1.
